// File: rtl/adder_pkg.sv
// Shared types for the chunked adder: FSM state encoding and sizing helpers.
package adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Index register width; never zero, even when there is a single chunk.
    function automatic int idx_width(input int num_chunks);
        return (num_chunks > 1) ? $clog2(num_chunks) : 1;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational WIDTH-bit adder slice; also reports the carry into its MSB
// so the caller can derive signed overflow on the top slice.
module chunk_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [WIDTH:0] full;

    always_comb begin
        full  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        s     = full[WIDTH-1:0];
        cout  = full[WIDTH];
        // a ^ b ^ sum at a bit position recovers the carry that entered it
        c_msb = a[WIDTH-1] ^ b[WIDTH-1] ^ full[WIDTH-1];
    end

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle adder: adds CHUNK_WIDTH bits per clock, ripple carry held in a
// register between chunks. valid/ready on both sides: a transfer happens on
// a rising edge where valid and ready are both 1; ready never depends on valid.
module chunked_adder
    import adder_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int CHUNK_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] data_in_a,
    input  logic [DATA_WIDTH-1:0] data_in_b,
    input  logic                  carry_in,
    output logic [DATA_WIDTH-1:0] op_a_out,
    output logic [DATA_WIDTH-1:0] op_b_out,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  carry_out,
    output logic                  overflow,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            state_dbg
);

    localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
    localparam int IDX_W      = idx_width(NUM_CHUNKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    if (DATA_WIDTH <= 0 || CHUNK_WIDTH <= 0 || (DATA_WIDTH % CHUNK_WIDTH) != 0) begin : g_bad_params
        $error("chunked_adder: DATA_WIDTH must be a nonzero multiple of CHUNK_WIDTH");
    end

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic                  carry_q, carry_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  carry_out_q, carry_out_d;
    logic                  overflow_q, overflow_d;

    logic [CHUNK_WIDTH-1:0] a_chunk, b_chunk, s_chunk;
    logic                   c_out, c_msb;
    int                     base;

    always_comb begin
        base    = int'(idx_q) * CHUNK_WIDTH;
        a_chunk = a_q[base +: CHUNK_WIDTH];
        b_chunk = b_q[base +: CHUNK_WIDTH];
    end

    chunk_adder #(.WIDTH(CHUNK_WIDTH)) u_chunk (
        .a     (a_chunk),
        .b     (b_chunk),
        .cin   (carry_q),
        .s     (s_chunk),
        .cout  (c_out),
        .c_msb (c_msb)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d         = data_in_a;
                    b_d         = data_in_b;
                    carry_d     = carry_in;
                    idx_d       = '0;
                    sum_d       = '0;
                    carry_out_d = 1'b0;
                    overflow_d  = 1'b0;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[base +: CHUNK_WIDTH] = s_chunk;
                carry_d = c_out;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    carry_out_d = c_out;
                    overflow_d  = c_msb ^ c_out;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign op_a_out  = a_q;
    assign op_b_out  = b_q;
    assign sum       = sum_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign state_dbg = state_q;

endmodule
